// File: rtl/edg_sched_pkg.sv
// Shared types and widths for the edge-detection frame scheduler.
package edg_sched_pkg;

  localparam int ADDR_W = 19;
  localparam int PAIR_W = 36;
  localparam int HC_W   = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_STREAM,
    ST_DRAIN,
    ST_NEXT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/edg_lat_pipe.sv
// Fixed-depth delay line carrying a valid tag and its pair address.
// Stage i becomes visible i+1 cycles after vld_i; vld_line_o exposes every
// stage so the parent can tap intermediate latencies and detect emptiness.
module edg_lat_pipe
  import edg_sched_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DEPTH-1:0]  vld_line_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  // Shift tags one stage per cycle; a clear drops every pending tag.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o      = vld_q[DEPTH-1];
  assign addr_o     = addr_q[DEPTH-1];
  assign vld_line_o = vld_q;

endmodule

// File: rtl/edg_sched.sv
// Frame scheduler: streams frame-buffer pairs into the edge engine and
// writes the results back. Optional macro EDG_SCHED_STATS_EN adds the
// frame_cycles output (start-to-done cycle count of the last full frame).
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | rd_req high, waiting for grant, hcount held at 0
// STREAM | one rd_en every second cycle for the line's pairs
// DRAIN  | waiting for the line's last write-back
// NEXT   | advance line counter
// DONE   | done pulse, back to IDLE
module edg_sched
  import edg_sched_pkg::*;
#(
  parameter int                HPIX    = 1024,
  parameter int                VLINES  = 768,
  parameter int                RD_LAT  = 2,
  parameter int                EDG_LAT = 4,
  parameter logic [ADDR_W-1:0] RD_BASE = '0,
  parameter logic [ADDR_W-1:0] WR_BASE = 19'h40000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              gs_mode,
  input  logic              so_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PAIR_W-1:0] rd_data,
  output logic [PAIR_W-1:0] two_pixel_vals,
  output logic [HC_W-1:0]   hcount,
  output logic              gs_switch,
  output logic              so_switch,
  input  logic [PAIR_W-1:0] proc_pixs,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PAIR_W-1:0] wr_data
`ifdef EDG_SCHED_STATS_EN
  ,
  output logic [23:0]       frame_cycles
`endif
);

  localparam int              PAIRS     = HPIX / 2;
  localparam int              DEPTH     = RD_LAT + EDG_LAT;
  localparam logic [HC_W-1:0] K_LAST    = HC_W'(PAIRS - 1);
  localparam logic [15:0]     LINE_LAST = 16'(VLINES - 1);

  state_e            state_q, state_d;
  logic              abort;
  logic [HC_W-1:0]   k_q;
  logic              ph_q;
  logic [ADDR_W-1:0] off_q;
  logic [15:0]       line_q;
  logic              err_q, gs_q, so_q;
  logic [PAIR_W-1:0] tpv_q;
  logic [HC_W-1:0]   hc_q, pk_q;
  logic              sec_q;
  logic              tag_vld;
  logic [ADDR_W-1:0] tag_addr;
  logic [DEPTH-1:0]  vld_line;
  logic [DEPTH:0]    tap;
  logic              cap;
  logic              pipe_busy;

  // Write-back tag: the running pair offset (line*HPIX/2 + k) rides along.
  edg_lat_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk        (clk),
    .rst_n_i    (reset),
    .clr_i      (abort),
    .vld_i      (rd_en),
    .addr_i     (off_q),
    .vld_o      (tag_vld),
    .addr_o     (tag_addr),
    .vld_line_o (vld_line)
  );

  // tap[i] is rd_en delayed by i cycles; capture one cycle before presentation.
  assign tap       = {vld_line, rd_en};
  assign cap       = tap[RD_LAT-1];
  assign pipe_busy = |vld_line;

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_req  = 1'b0;
    rd_en   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_gnt) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (!rd_gnt) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (!ph_q) begin
          rd_en = 1'b1;
          if (k_q == K_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        busy    = 1'b1;
        state_d = (line_q == LINE_LAST) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus line/pair counters, mode latches and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      ph_q    <= 1'b0;
      off_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      gs_q    <= 1'b0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        gs_q   <= gs_mode;
        so_q   <= so_mode;
        err_q  <= 1'b0;
        line_q <= '0;
        off_q  <= '0;
      end
      if (abort) err_q <= 1'b1;
      if (state_q == ST_REQ) begin
        k_q  <= '0;
        ph_q <= 1'b0;
      end
      if (state_q == ST_STREAM) begin
        ph_q <= ~ph_q;
        if (rd_en) begin
          k_q   <= k_q + 1'b1;
          off_q <= off_q + 1'b1;
        end
      end
      if (state_q == ST_NEXT) line_q <= line_q + 1'b1;
    end
  end

  // Present each returned pair for two cycles with hcount 2k then 2k+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tpv_q <= '0;
      hc_q  <= '0;
      pk_q  <= '0;
      sec_q <= 1'b0;
    end else if (abort) begin
      tpv_q <= '0;
      sec_q <= 1'b0;
    end else if (state_d == ST_REQ) begin
      tpv_q <= '0;
      hc_q  <= '0;
      pk_q  <= '0;
      sec_q <= 1'b0;
    end else if (cap) begin
      tpv_q <= rd_data;
      hc_q  <= {pk_q[HC_W-2:0], 1'b0};
      pk_q  <= pk_q + 1'b1;
      sec_q <= 1'b1;
    end else if (sec_q) begin
      hc_q  <= hc_q + 1'b1;
      sec_q <= 1'b0;
    end else begin
      tpv_q <= '0;
    end
  end

`ifdef EDG_SCHED_STATS_EN
  logic [23:0] cyc_q, fc_q;

  // Count from accepted start; publish only when the frame reaches DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      fc_q  <= '0;
    end else begin
      if (state_q == ST_IDLE) cyc_q <= start ? 24'd1 : 24'd0;
      else if (cyc_q != '1)   cyc_q <= cyc_q + 1'b1;
      if (state_q == ST_DONE) fc_q <= cyc_q;
    end
  end

  assign frame_cycles = fc_q;
`endif

  assign err            = err_q;
  assign gs_switch      = gs_q;
  assign so_switch      = so_q;
  assign two_pixel_vals = tpv_q;
  assign hcount         = hc_q;
  assign rd_addr        = rd_en ? (RD_BASE + off_q) : '0;
  assign wr_en          = tag_vld;
  assign wr_addr        = tag_vld ? (WR_BASE + tag_addr) : '0;
  assign wr_data        = tag_vld ? proc_pixs : '0;

endmodule

// File: tb/tb_edg_sched.sv
`timescale 1ns/1ps
module tb_edg_sched;

  localparam int          HPIX    = 8;
  localparam int          VLINES  = 2;
  localparam int          RD_LAT  = 2;
  localparam int          EDG_LAT = 4;
  localparam int          PAIRS   = HPIX / 2;
  localparam logic [18:0] RD_BASE = 19'h0;
  localparam logic [18:0] WR_BASE = 19'h40000;
  localparam int          FRAME_CYC = 33; // 2 lines x 16 cycles + DONE offset

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic        gs_mode = 1'b0, so_mode = 1'b0, rd_gnt = 1'b0;
  logic [35:0] rd_data = '0, proc_pixs = '0;
  logic        busy, done, err, rd_req, rd_en, gs_switch, so_switch, wr_en;
  logic [18:0] rd_addr, wr_addr;
  logic [35:0] two_pixel_vals, wr_data;
  logic [10:0] hcount;
`ifdef EDG_SCHED_STATS_EN
  logic [23:0] frame_cycles;
`endif

  edg_sched #(
    .HPIX(HPIX), .VLINES(VLINES), .RD_LAT(RD_LAT), .EDG_LAT(EDG_LAT),
    .RD_BASE(RD_BASE), .WR_BASE(WR_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .gs_mode(gs_mode), .so_mode(so_mode),
    .busy(busy), .done(done), .err(err), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .two_pixel_vals(two_pixel_vals), .hcount(hcount),
    .gs_switch(gs_switch), .so_switch(so_switch), .proc_pixs(proc_pixs),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef EDG_SCHED_STATS_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  typedef struct {
    int          due;
    logic [35:0] tpv;
    logic [10:0] hc;
  } pres_t;

  pres_t       pres_q[$];
  logic [18:0] exp_ra_q[$];
  logic [18:0] exp_wa_q[$];
  logic [35:0] exp_wd_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, wr_seen = 0;

  always #5 clk = ~clk;

  function automatic logic [35:0] mem_word(input logic [18:0] a);
    return {a[16:0], 1'b1, a[16:0], 1'b0};
  endfunction

  function automatic logic [35:0] pat(input int c);
    return {4'hA, 32'(c)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter; engine result is a known function of the cycle.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    proc_pixs = pat(cyc);
  end

  // Frame-buffer model: answer each read and hold the word until the next.
  initial forever begin
    @(negedge clk);
    if (rd_en) rd_data = mem_word(rd_addr);
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    logic [18:0] ea;
    logic [10:0] hc0;
    pres_t       p;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        if (exp_ra_q.size() == 0) chk("unexpected_rd_en", 1, 0);
        else begin
          ea = exp_ra_q.pop_front();
          chk("rd_addr", rd_addr, ea);
          hc0 = 11'(2 * (ea % PAIRS));
          pres_q.push_back('{cyc + RD_LAT,     mem_word(ea), hc0});
          pres_q.push_back('{cyc + RD_LAT + 1, mem_word(ea), hc0 + 11'd1});
          exp_wd_q.push_back(pat(cyc + RD_LAT + EDG_LAT));
        end
      end
      if (pres_q.size() > 0 && pres_q[0].due == cyc) begin
        p = pres_q.pop_front();
        chk("two_pixel_vals", two_pixel_vals, p.tpv);
        chk("hcount", hcount, p.hc);
      end
      if (wr_en) begin
        wr_seen++;
        if (exp_wa_q.size() == 0 || exp_wd_q.size() == 0) chk("unexpected_wr_en", 1, 0);
        else begin
          chk("wr_addr", wr_addr, exp_wa_q.pop_front());
          chk("wr_data", wr_data, exp_wd_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame();
    for (int i = 0; i < HPIX / 2 * VLINES; i++) begin
      exp_ra_q.push_back(RD_BASE + 19'(i));
      exp_wa_q.push_back(WR_BASE + 19'(i));
    end
  endtask

  task automatic do_start();
    next_cyc();
    start = 1'b1;
    start_cyc = cyc;
    next_cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic wait_rd(input int count, input int budget);
    int n, seen;
    n = 0;
    seen = 0;
    while (seen < count && n < budget) begin
      @(negedge clk);
      if (rd_en) seen++;
      n++;
    end
    if (seen < count) chk("rd_en_timeout", seen, count);
  endtask

  initial begin
    int wr0;
    // Reset state
    #23;
    chk("reset_ctrl", {busy, done, err, rd_req, rd_en, wr_en, gs_switch, so_switch}, 0);
    chk("reset_data", {rd_addr, wr_addr, hcount, two_pixel_vals, wr_data}, 0);
    next_cyc();
    reset = 1'b1;

    // Nominal frame, grant tied high
    rd_gnt  = 1'b1;
    so_mode = 1'b1;
    push_frame();
    do_start();
    chk("nom_busy", busy, 1);
    chk("nom_modes", {gs_switch, so_switch}, 2'b01);
    wait_done(1, 300);
    chk("nom_frame_len", done_cyc - start_cyc, FRAME_CYC);
    next_cyc();
    next_cyc();
    chk("nom_done_count", done_cnt, 1);
    chk("nom_busy_after", busy, 0);
    chk("nom_err", err, 0);
    chk("nom_writes_left", exp_wa_q.size(), 0);
`ifdef EDG_SCHED_STATS_EN
    chk("frame_cycles", frame_cycles, FRAME_CYC);
`endif

    // Delayed grant, and a start with gs_mode=1 mid-frame
    rd_gnt  = 1'b0;
    so_mode = 1'b0;
    push_frame();
    do_start();
    for (int i = 0; i < 10; i++) begin
      chk("dly_rd_req", rd_req, 1);
      chk("dly_rd_en", rd_en, 0);
      chk("dly_hcount", hcount, 0);
      next_cyc();
    end
    rd_gnt = 1'b1;
    next_cyc();
    chk("dly_first_rd_en", rd_en, 1);
    repeat (6) next_cyc();
    gs_mode = 1'b1;
    start   = 1'b1;
    next_cyc();
    start   = 1'b0;
    gs_mode = 1'b0;
    next_cyc();
    chk("busy_start_gs", gs_switch, 0);
    chk("busy_start_busy", busy, 1);
    wait_done(2, 400);
    next_cyc();
    chk("dly_done_count", done_cnt, 2);
    chk("dly_gs_kept", gs_switch, 0);
    chk("dly_writes_left", exp_wa_q.size(), 0);

    // Grant lost after the read for k=2
    for (int i = 0; i < 3; i++) exp_ra_q.push_back(RD_BASE + 19'(i));
    rd_gnt = 1'b1;
    do_start();
    wait_rd(3, 50);
    next_cyc();
    rd_gnt = 1'b0;
    while (pres_q.size() > 0 && pres_q[$].due > cyc) void'(pres_q.pop_back());
    exp_wd_q.delete();
    wr0 = wr_seen;
    next_cyc();
    chk("lost_err", err, 1);
    chk("lost_busy", busy, 0);
    chk("lost_rd_req", rd_req, 0);
    repeat (20) next_cyc();
    chk("lost_no_wr", wr_seen, wr0);
    chk("lost_no_done", done_cnt, 2);
    chk("lost_err_sticky", err, 1);
    rd_gnt  = 1'b1;
    gs_mode = 1'b1;
    push_frame();
    do_start();
    gs_mode = 1'b0;
    chk("restart_err_clr", err, 0);
    chk("restart_gs", gs_switch, 1);
    wait_done(3, 300);
    next_cyc();
    chk("restart_done_count", done_cnt, 3);
    chk("restart_writes_left", exp_wa_q.size(), 0);
`ifdef EDG_SCHED_STATS_EN
    chk("frame_cycles_restart", frame_cycles, FRAME_CYC);
`endif

    // Asynchronous reset mid-STREAM
    push_frame();
    do_start();
    wait_rd(2, 50);
    @(posedge clk);
    #3;
    reset = 1'b0;
    pres_q.delete();
    exp_ra_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    #1;
    chk("rst_ctrl", {busy, done, err, rd_req, rd_en, wr_en, gs_switch, so_switch}, 0);
    chk("rst_data", {rd_addr, wr_addr, hcount, two_pixel_vals, wr_data}, 0);
    wr0 = wr_seen;
    next_cyc();
    reset = 1'b1;
    repeat (20) next_cyc();
    chk("rst_no_wr", wr_seen, wr0);
    chk("rst_idle", {busy, rd_req}, 0);
`ifdef EDG_SCHED_STATS_EN
    chk("rst_frame_cycles", frame_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/edg_sched.md
# edg_sched

Frame-level scheduler for the pixel-pair edge-detection datapath. Per line, it requests the frame-buffer read port and streams two-pixel words into the edge engine at one pair per two cycles. It drives the engine's `hcount` phase, aligns the engine's output latency, and writes the processed pairs back to a result buffer. It sits between the memory arbiter and the edge wrapper and owns the `gs_switch` and `so_switch` mode lines.

## Interface
Parameters:
- `HPIX`, 1024: pixels per line. Must be even and at least 4.
- `VLINES`, 768: lines per frame.
- `RD_LAT`, 2: cycles from `rd_en` to valid `rd_data`.
- `EDG_LAT`, 4: cycles from first presentation of a pair to valid `proc_pixs`.
- `RD_BASE`, 0: word address of the source frame.
- `WR_BASE`, 'h40000: word address of the result frame.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low.
- `start`, in, 1: one-cycle frame request. Honoured only in IDLE.
- `gs_mode`, `so_mode`, in, 1 each: mode requests, latched at accepted `start`.
- `busy`, out, 1: high from the cycle after accepted `start` until DONE.
- `done`, out, 1: one-cycle pulse at end of frame.
- `err`, out, 1: sticky flag for grant lost mid-line. Cleared by next accepted `start`.
- `rd_req`, out, 1: line-burst request to the memory arbiter.
- `rd_gnt`, in, 1: grant. Must stay high for the whole burst.
- `rd_en`, out, 1: read strobe.
- `rd_addr`, out, 19: read word address.
- `rd_data`, in, 36: two 18-bit RGB666 pixels; the lower pixel is in bits [17:0].
- `two_pixel_vals`, out, 36: pair to the engine.
- `hcount`, out, 11: engine phase/pixel index.
- `gs_switch`, `so_switch`, out, 1 each: latched modes.
- `proc_pixs`, in, 36: engine result.
- `wr_en`, out, 1: result write strobe.
- `wr_addr`, out, 19: result write address.
- `wr_data`, out, 36: result write data.

## Operation
- The states are IDLE, REQ, STREAM, DRAIN, NEXT and DONE.
- **IDLE → REQ** on `start`. In this transition the block latches the modes, clears `err` and sets line = 0.
  - `start` is ignored in every other state.
- **REQ:** `rd_req` is high. The block waits indefinitely for `rd_gnt`, with `hcount` held at 0.
  - **REQ → STREAM** on the cycle `rd_gnt` is sampled high.
- **STREAM:** the pair index k runs from 0 to HPIX/2−1.
  - `rd_en` pulses on every second cycle.
  - `rd_addr = RD_BASE + line·HPIX/2 + k`.
  - `rd_req` drops in the cycle after the last `rd_en`.
  - The block then goes to DRAIN.
- **Grant loss:** if `rd_gnt` is low at any STREAM cycle while `rd_req` is high, the block sets `err`, drops `rd_req`, and goes directly to IDLE.
  - No further `rd_en` or `wr_en` is issued, pending tags are cleared, and `done` is not pulsed.
- **Presentation:** `rd_data` is registered into `two_pixel_vals` when it arrives and held for 2 cycles.
  - `hcount` is 2k on the first cycle of pair k and 2k+1 on the second.
  - Outside presentation, `two_pixel_vals` is 0 and `hcount` holds its last value.
- **Write-back:** a valid tag plus address travels RD_LAT+EDG_LAT cycles.
  - When the tag emerges, `wr_en` is high for one cycle, `wr_data = proc_pixs` and `wr_addr = WR_BASE + line·HPIX/2 + k`.
- **DRAIN → NEXT** in the cycle after the final `wr_en` of the line.
- **NEXT:** line is incremented. Go to REQ if lines remain, otherwise to DONE.
- **DONE:** `done` is pulsed, `busy` drops, and the block returns to IDLE.
- **Reset:** reset is asynchronous at any time. Every output is 0 in reset; `hcount` is also 0. State returns to IDLE.

## Timing
- A `rd_en` in cycle t produces the first presentation cycle at t+RD_LAT.
- The `wr_en` for that pair occurs at t+RD_LAT+EDG_LAT.
- Line duration from the REQ grant to NEXT is HPIX + RD_LAT + EDG_LAT + 1 cycles.
- `rd_req` deasserts at most 1 cycle after the last read.
- Mode outputs change only on the IDLE→REQ transition.
- Address arithmetic is 19-bit and wraps modulo 2^19; the block does no overflow check.

## Configuration
- Macro: `EDG_SCHED_STATS_EN`.
- **Defined:** adds output `frame_cycles[23:0]`.
  - It holds the cycle count from accepted `start` to `done` of the last completed frame, saturating at 2^24−1.
  - It is 0 after reset.
  - An aborted frame does not update it.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- Package `edg_sched_pkg`:
  - the state enum;
  - `ADDR_W = 19`;
  - `PAIR_W = 36`.
- One sub-module, `edg_lat_pipe`: a parameterised-depth delay line for the valid bit and the 19-bit address. It is clearable by abort and reset.

## Test plan
Unless noted, tests use HPIX=8, VLINES=2, RD_LAT=2, EDG_LAT=4, RD_BASE=0 and WR_BASE='h40000.

- **Reset:** assert reset mid-STREAM → all outputs are 0 asynchronously, IDLE is entered, and no `wr_en` appears after release.
- **Nominal frame:** `rd_gnt` tied high → `rd_addr` is 0,1,2,3 then 4,5,6,7, and there are exactly 8 `wr_en` pulses.
  - `wr_addr` is 'h40000 through 'h40007 in order.
  - `wr_data` is `proc_pixs` sampled 6 cycles after each `rd_en`.
  - There is one `done` pulse and `err` stays 0.
- **Delayed grant:** hold `rd_gnt` low for 10 cycles → `rd_req` stays high, with no `rd_en` and `hcount` at 0. The first `rd_en` follows the grant.
- **Grant lost:** drop `rd_gnt` after the `rd_en` for k=2 → `err` is 1, `busy` is 0 the next cycle, and no `done` or further `wr_en` occurs.
  - A following `start` clears `err`.
- **Start while busy:** `start` with `gs_mode=1` mid-frame is ignored and `gs_switch` keeps its latched value.
- **Stats** (with `EDG_SCHED_STATS_EN` defined): after the nominal frame, `frame_cycles` equals the measured start-to-done cycle count.
